// File: rtl/iir_pkg.sv
// Shared types, tap/state encodings and the inter-section saturator for the
// time-multiplexed biquad cascade.
package iir_pkg;

    typedef logic signed [17:0] coef_t;
    typedef logic signed [44:0] acc_t;
    typedef logic signed [15:0] sample_t;

    localparam int NTAPS     = 5;
    localparam int B_SHIFT   = 8;
    localparam int Y_SHIFT   = 16;
    localparam int OUT_SHIFT = 24;

    typedef enum logic [2:0] {
        B1 = 3'd0,
        B2 = 3'd1,
        B3 = 3'd2,
        A2 = 3'd3,
        A3 = 3'd4
    } tap_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2
    } state_e;

    function automatic sample_t sat16(input acc_t v);
        if (v > acc_t'(32767))
            return sample_t'(32767);
        else if (v < acc_t'(-32768))
            return sample_t'(-32768);
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Double-buffered coefficient store: host writes land in the shadow bank and
// are promoted to the active bank only at a frame start with a swap pending.
module iir_coef_bank
    import iir_pkg::*;
#(
    parameter int NSEC = 4,
    parameter int AW   = $clog2(NSEC * 5),
    parameter int SW   = (NSEC > 1) ? $clog2(NSEC) : 1
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  coef_t         coef_wdata,
    input  logic          coef_swap,
    input  logic          load,
    input  logic [SW-1:0] rd_sec,
    input  tap_e          rd_tap,
    output coef_t         rd_coef
);

    localparam int NCOEF = NSEC * NTAPS;

    coef_t         shadow_q [NCOEF];
    coef_t         active_q [NCOEF];
    coef_t         shadow_d [NCOEF];
    logic          swap_pend;
    logic          swap_go;
    logic [AW-1:0] rd_idx;

    // A swap arriving together with the frame start is honoured immediately,
    // and a same-cycle write is part of what gets promoted.
    assign swap_go = load & (swap_pend | coef_swap);

    always_comb begin
        for (int i = 0; i < NCOEF; i++)
            shadow_d[i] = shadow_q[i];
        if (coef_we && (int'(coef_addr) < NCOEF))
            shadow_d[coef_addr] = coef_wdata;
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            swap_pend <= 1'b0;
        end else begin
            for (int i = 0; i < NCOEF; i++)
                shadow_q[i] <= shadow_d[i];
            if (swap_go)
                for (int i = 0; i < NCOEF; i++)
                    active_q[i] <= shadow_d[i];
            swap_pend <= (swap_pend | coef_swap) & ~load;
        end
    end

    assign rd_idx  = AW'(int'(rd_sec) * NTAPS + int'(rd_tap));
    assign rd_coef = active_q[rd_idx];

endmodule

// File: rtl/iir_cascade_sequencer.sv
// Cascade of NSEC biquads sharing one MAC: five taps per section, one
// write-back cycle, each section's saturated output feeding the next.
module iir_cascade_sequencer
    import iir_pkg::*;
#(
    parameter int NSEC = 4
) (
    input  logic                        clk,
    input  logic                        i_rst,
    input  logic                        lrclk_posedge,
    input  logic                        i_valid,
    input  logic signed [15:0]          x_in,
    input  logic                        coef_we,
    input  logic [$clog2(NSEC*5)-1:0]   coef_addr,
    input  logic signed [17:0]          coef_wdata,
    input  logic                        coef_swap,
    output logic signed [20:0]          audio_out,
    output logic                        o_out_valid,
    output logic                        o_busy,
    output logic                        o_overrun
);

    localparam int AW = $clog2(NSEC * NTAPS);
    localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;

    state_e        state;
    logic [SW-1:0] sec;
    tap_e          tap;
    acc_t          acc;
    sample_t       xin;
    sample_t       x1_q [NSEC];
    sample_t       x2_q [NSEC];
    acc_t          y1_q [NSEC];
    acc_t          y2_q [NSEC];

    coef_t         coef;
    acc_t          mul_a;
    acc_t          prod;
    acc_t          mac_term;
    acc_t          y_new;
    acc_t          s_out;
    logic          frame_start;
    logic          last_sec;

    assign frame_start = (state == IDLE) & lrclk_posedge & i_valid;
    assign last_sec    = (sec == SW'(NSEC - 1));
    assign o_overrun   = lrclk_posedge & o_busy;

    iir_coef_bank #(
        .NSEC (NSEC),
        .AW   (AW),
        .SW   (SW)
    ) u_coef_bank (
        .clk        (clk),
        .i_rst      (i_rst),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_swap  (coef_swap),
        .load       (frame_start),
        .rd_sec     (sec),
        .rd_tap     (tap),
        .rd_coef    (coef)
    );

    // Feed-forward products carry 8 extra fraction bits so they line up with
    // the y history, which is kept at acc >>> 16 rather than at sample scale.
    always_comb begin
        mul_a = '0;
        case (tap)
            B1:      mul_a = acc_t'(xin);
            B2:      mul_a = acc_t'(x1_q[sec]);
            B3:      mul_a = acc_t'(x2_q[sec]);
            A2:      mul_a = y1_q[sec];
            A3:      mul_a = y2_q[sec];
            default: mul_a = '0;
        endcase
        prod     = mul_a * acc_t'(coef);
        mac_term = (tap == A2 || tap == A3) ? prod : (prod <<< B_SHIFT);
        y_new    = acc >>> Y_SHIFT;
        s_out    = acc >>> OUT_SHIFT;
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            sec         <= '0;
            tap         <= B1;
            acc         <= '0;
            xin         <= '0;
            audio_out   <= '0;
            o_out_valid <= 1'b0;
            o_busy      <= 1'b0;
            for (int i = 0; i < NSEC; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            o_out_valid <= 1'b0;
            if (!i_valid) begin
                state     <= IDLE;
                sec       <= '0;
                tap       <= B1;
                acc       <= '0;
                xin       <= '0;
                audio_out <= '0;
                o_busy    <= 1'b0;
                for (int i = 0; i < NSEC; i++) begin
                    x1_q[i] <= '0;
                    x2_q[i] <= '0;
                    y1_q[i] <= '0;
                    y2_q[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (lrclk_posedge) begin
                            xin    <= x_in;
                            acc    <= '0;
                            sec    <= '0;
                            tap    <= B1;
                            o_busy <= 1'b1;
                            state  <= MAC;
                        end
                    end
                    MAC: begin
                        acc <= acc + mac_term;
                        if (tap == A3)
                            state <= WB;
                        else
                            tap <= tap_e'(tap + 3'd1);
                    end
                    WB: begin
                        x2_q[sec] <= x1_q[sec];
                        x1_q[sec] <= xin;
                        y2_q[sec] <= y1_q[sec];
                        y1_q[sec] <= y_new;
                        xin       <= sat16(s_out);
                        acc       <= '0;
                        tap       <= B1;
                        if (last_sec) begin
                            audio_out   <= {s_out[44], s_out[19:0]};
                            o_out_valid <= 1'b1;
                            o_busy      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            sec   <= sec + SW'(1);
                            state <= MAC;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iir_cascade_sequencer.sv
// Directed bench for a two-section cascade with hand-computed results.
module tb_iir_cascade_sequencer;

    localparam int NSEC = 2;

    logic               clk = 1'b0;
    logic               i_rst;
    logic               lrclk_posedge;
    logic               i_valid;
    logic signed [15:0] x_in;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic signed [17:0] coef_wdata;
    logic               coef_swap;
    logic signed [20:0] audio_out;
    logic               o_out_valid;
    logic               o_busy;
    logic               o_overrun;

    int vectors     = 0;
    int miscompares = 0;

    iir_cascade_sequencer #(.NSEC(NSEC)) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .lrclk_posedge (lrclk_posedge),
        .i_valid       (i_valid),
        .x_in          (x_in),
        .coef_we       (coef_we),
        .coef_addr     (coef_addr),
        .coef_wdata    (coef_wdata),
        .coef_swap     (coef_swap),
        .audio_out     (audio_out),
        .o_out_valid   (o_out_valid),
        .o_busy        (o_busy),
        .o_overrun     (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int val);
        coef_we    = 1'b1;
        coef_addr  = 4'(addr);
        coef_wdata = 18'(val);
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic swap();
        coef_swap = 1'b1;
        tick();
        coef_swap = 1'b0;
    endtask

    task automatic clr();
        i_valid = 1'b0;
        tick();
        i_valid = 1'b1;
    endtask

    // Strobe in the current cycle T, then follow through T+14.
    task automatic frame(input string tag, input int x, input int exp);
        lrclk_posedge = 1'b1;
        x_in          = 16'(x);
        #1;
        chk({tag, ".ovr"}, o_overrun, 0);
        for (int k = 1; k <= 14; k++) begin
            tick();
            lrclk_posedge = 1'b0;
            chk($sformatf("%s.busy%0d", tag, k), o_busy, (k <= 12));
            chk($sformatf("%s.ovalid%0d", tag, k), o_out_valid, (k == 13));
            if (k == 13)
                chk({tag, ".aout"}, audio_out, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int nvalid;
        i_rst = 1'b1; lrclk_posedge = 1'b0; i_valid = 1'b1; x_in = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; coef_swap = 1'b0;
        tick(); tick();
        chk("rst.aout", audio_out, 0);
        chk("rst.ovalid", o_out_valid, 0);
        chk("rst.busy", o_busy, 0);
        chk("rst.ovr", o_overrun, 0);
        i_rst = 1'b0;
        tick();

        // pass-through
        wr(0, 65536); wr(5, 65536); swap();
        frame("pass", 1000, 1000);

        // one-pole feedback in section 0
        wr(3, 32768); swap(); clr();
        frame("pole0", 1000, 1000);
        frame("pole1", 0, 500);
        frame("pole2", 0, 250);
        frame("pole3", 0, 125);

        // inter-section saturation
        wr(0, 131071); wr(3, 0); swap(); clr();
        frame("satp", 32767, 32767);
        frame("satn", -32768, -32768);

        // overrun, then a strobe at exactly the minimum spacing
        wr(0, 65536); swap();
        lrclk_posedge = 1'b1; x_in = 16'sd1000;
        for (int k = 1; k <= 13; k++) begin
            tick();
            lrclk_posedge = 1'b0;
            if (k == 5) begin
                lrclk_posedge = 1'b1; x_in = 16'sd2000;
                #1;
                chk("ovr.pulse", o_overrun, 1);
            end
            if (k == 6) begin
                #1;
                chk("ovr.single", o_overrun, 0);
            end
            if (k == 13) begin
                chk("ovr.ovalid", o_out_valid, 1);
                chk("ovr.aout", audio_out, 1000);
            end
        end
        frame("spacing", 3000, 3000);

        // write + swap mid-frame: current frame keeps the old bank
        lrclk_posedge = 1'b1; x_in = 16'sd1000;
        for (int k = 1; k <= 13; k++) begin
            tick();
            lrclk_posedge = 1'b0; coef_we = 1'b0; coef_swap = 1'b0;
            if (k == 4) begin
                coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 18'sd32768; coef_swap = 1'b1;
            end
            if (k == 13) begin
                chk("swap.old.ovalid", o_out_valid, 1);
                chk("swap.old.aout", audio_out, 1000);
            end
        end
        frame("swap.new", 1000, 500);

        // i_valid drop mid-frame
        nvalid = 0;
        lrclk_posedge = 1'b1; x_in = 16'sd1000;
        for (int k = 1; k <= 14; k++) begin
            tick();
            lrclk_posedge = 1'b0;
            if (k == 7) i_valid = 1'b0;
            if (k == 8) begin
                i_valid = 1'b1;
                chk("drop.aout", audio_out, 0);
                chk("drop.busy", o_busy, 0);
            end
            nvalid += int'(o_out_valid);
        end
        chk("drop.novalid", nvalid, 0);
        frame("drop.retain", 1000, 500);

        // async reset mid-frame
        lrclk_posedge = 1'b1; x_in = 16'sd1000;
        for (int k = 1; k <= 6; k++) begin
            tick();
            lrclk_posedge = 1'b0;
        end
        i_rst = 1'b1;
        #1;
        chk("arst.aout", audio_out, 0);
        chk("arst.ovalid", o_out_valid, 0);
        chk("arst.busy", o_busy, 0);
        chk("arst.ovr", o_overrun, 0);
        tick();
        i_rst = 1'b0;
        tick();
        frame("arst.zerobank", 1000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
